// File: rtl/morse_pkg.sv
// Shared definitions for the morse transmit/receive pair.
// Contents: the receive FSM state encoding, the space and error
// characters, and the gap threshold multipliers. The multipliers are
// expressed in units of MORSE_CYCLES.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      MARK       = 2'd1,
      GAP        = 2'd2,
      LETTER_GAP = 2'd3
   } morse_state_e;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ERROR = 8'h3F;

   // Letter boundary threshold: gaps of this many units end a letter.
   localparam int unsigned LETTER_GAP_MULT = 2;
   // Word boundary threshold: gaps of this many units end a word.
   localparam int unsigned WORD_GAP_MULT   = 5;

   localparam int unsigned MAX_SYMBOLS = 6;

endpackage

// File: rtl/morse_code_to_ascii.sv
// Combinational reverse lookup from a morse symbol code to ASCII.
// Ports:
//   code  [5:0] in  : code[i] = 1 for dot, 0 for dash; i = 0 is sent first
//   len   [3:0] in  : number of valid symbols in code (0..6)
//   ascii [7:0] out : decoded character, or '?' on a miss
//   hit         out : 1 when code/len is one of A-Z, 0-9
module morse_code_to_ascii
   import morse_pkg::*;
(
   input  logic [5:0] code,
   input  logic [3:0] len,
   output logic [7:0] ascii,
   output logic       hit
);

   logic [5:0] masked;

   always_comb begin
      // Bits at or above len are not part of the letter.
      masked = code & ~(6'h3F << len);
      ascii  = ASCII_ERROR;
      hit    = 1'b1;
      case ({len, masked})
         {4'd2, 6'd1 }: ascii = "A";
         {4'd4, 6'd14}: ascii = "B";
         {4'd4, 6'd10}: ascii = "C";
         {4'd3, 6'd6 }: ascii = "D";
         {4'd1, 6'd1 }: ascii = "E";
         {4'd4, 6'd11}: ascii = "F";
         {4'd3, 6'd4 }: ascii = "G";
         {4'd4, 6'd15}: ascii = "H";
         {4'd2, 6'd3 }: ascii = "I";
         {4'd4, 6'd1 }: ascii = "J";
         {4'd3, 6'd2 }: ascii = "K";
         {4'd4, 6'd13}: ascii = "L";
         {4'd2, 6'd0 }: ascii = "M";
         {4'd2, 6'd2 }: ascii = "N";
         {4'd3, 6'd0 }: ascii = "O";
         {4'd4, 6'd9 }: ascii = "P";
         {4'd4, 6'd4 }: ascii = "Q";
         {4'd3, 6'd5 }: ascii = "R";
         {4'd3, 6'd7 }: ascii = "S";
         {4'd1, 6'd0 }: ascii = "T";
         {4'd3, 6'd3 }: ascii = "U";
         {4'd4, 6'd7 }: ascii = "V";
         {4'd3, 6'd1 }: ascii = "W";
         {4'd4, 6'd6 }: ascii = "X";
         {4'd4, 6'd2 }: ascii = "Y";
         {4'd4, 6'd12}: ascii = "Z";
         {4'd5, 6'd0 }: ascii = "0";
         {4'd5, 6'd1 }: ascii = "1";
         {4'd5, 6'd3 }: ascii = "2";
         {4'd5, 6'd7 }: ascii = "3";
         {4'd5, 6'd15}: ascii = "4";
         {4'd5, 6'd31}: ascii = "5";
         {4'd5, 6'd30}: ascii = "6";
         {4'd5, 6'd28}: ascii = "7";
         {4'd5, 6'd24}: ascii = "8";
         {4'd5, 6'd16}: ascii = "9";
         default: begin
            ascii = ASCII_ERROR;
            hit   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: measures mark/space durations of a serial morse signal
// and emits one ASCII byte per letter plus one space per word gap.
// Ports:
//   clk_i         in  : clock
//   reset_i       in  : synchronous active-high reset
//   morse_i       in  : asynchronous morse signal, 1 = mark
//   ascii_o [7:0] out : decoded character, held until the next emission
//   valid_o       out : one-cycle pulse qualifying ascii_o / err_o
//   err_o         out : unknown code or more than 6 symbols
//   busy_o        out : letter or word gap pending
module morse_decoder
   import morse_pkg::*;
#(
   parameter int unsigned MORSE_CYCLES = 10
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       morse_i,
   output logic [7:0] ascii_o,
   output logic       valid_o,
   output logic       err_o,
   output logic       busy_o
);

   localparam int unsigned LETTER_LIMIT = LETTER_GAP_MULT * MORSE_CYCLES;
   localparam int unsigned WORD_LIMIT   = WORD_GAP_MULT * MORSE_CYCLES;
   localparam int unsigned COUNTER_BITS = $clog2(WORD_LIMIT) + 1;

   localparam logic [COUNTER_BITS-1:0] DASH_MIN   = COUNTER_BITS'(LETTER_LIMIT);
   localparam logic [COUNTER_BITS-1:0] LETTER_HIT = COUNTER_BITS'(LETTER_LIMIT - 1);
   localparam logic [COUNTER_BITS-1:0] WORD_HIT   = COUNTER_BITS'(WORD_LIMIT - 1);
   localparam logic [COUNTER_BITS-1:0] COUNT_MAX  = COUNTER_BITS'(WORD_LIMIT);

   logic [1:0]              sync_q;
   logic                    m_s;
   morse_state_e            state_q, state_n;
   logic [COUNTER_BITS-1:0] count_q, count_n;
   logic [5:0]              code_q, code_n;
   logic [3:0]              len_q, len_n;
   logic                    ovf_q, ovf_n;
   logic [7:0]              ascii_n;
   logic                    valid_n, err_n;
   logic                    keep_count;
   logic [7:0]              lut_ascii;
   logic                    lut_hit;

   assign m_s    = sync_q[1];
   assign busy_o = (state_q != IDLE);

   morse_code_to_ascii u_lookup (
      .code  (code_q),
      .len   (len_q),
      .ascii (lut_ascii),
      .hit   (lut_hit)
   );

   always_comb begin
      state_n    = state_q;
      code_n     = code_q;
      len_n      = len_q;
      ovf_n      = ovf_q;
      valid_n    = 1'b0;
      ascii_n    = ascii_o;
      err_n      = err_o;
      keep_count = 1'b0;

      case (state_q)
         IDLE: begin
            code_n = '0;
            len_n  = '0;
            ovf_n  = 1'b0;
            if (m_s) state_n = MARK;
         end
         MARK: begin
            if (!m_s) begin
               if (len_q < 4'(MAX_SYMBOLS)) begin
                  code_n[len_q[2:0]] = (count_q < DASH_MIN);
                  len_n              = len_q + 4'd1;
               end else begin
                  ovf_n = 1'b1;
               end
               state_n = GAP;
            end
         end
         GAP: begin
            if (m_s) begin
               state_n = MARK;
            end else if (count_q == LETTER_HIT) begin
               valid_n = 1'b1;
               if (ovf_q || !lut_hit) begin
                  ascii_n = ASCII_ERROR;
                  err_n   = 1'b1;
               end else begin
                  ascii_n = lut_ascii;
                  err_n   = 1'b0;
               end
               state_n    = LETTER_GAP;
               // Word gap is timed from the end of the last mark, so the
               // count carries on through LETTER_GAP instead of restarting.
               keep_count = 1'b1;
            end
         end
         LETTER_GAP: begin
            if (m_s) begin
               code_n  = '0;
               len_n   = '0;
               ovf_n   = 1'b0;
               state_n = MARK;
            end else if (count_q == WORD_HIT) begin
               valid_n = 1'b1;
               ascii_n = ASCII_SPACE;
               err_n   = 1'b0;
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            code_n  = '0;
            len_n   = '0;
            ovf_n   = 1'b0;
            ascii_n = '0;
            err_n   = 1'b0;
         end
      endcase

      if ((state_n != state_q) && !keep_count) begin
         count_n = '0;
      end else if ((state_q != IDLE) && (count_q != COUNT_MAX)) begin
         count_n = count_q + COUNTER_BITS'(1);
      end else begin
         count_n = count_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q  <= '0;
         state_q <= IDLE;
         count_q <= '0;
         code_q  <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
         ascii_o <= '0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], morse_i};
         state_q <= state_n;
         count_q <= count_n;
         code_q  <= code_n;
         len_q   <= len_n;
         ovf_q   <= ovf_n;
         ascii_o <= ascii_n;
         valid_o <= valid_n;
         err_o   <= err_n;
      end
   end

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder (MORSE_CYCLES = 10).
module tb_morse_decoder;

   localparam int unsigned MC = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       morse;
   logic [7:0] ascii;
   logic       valid, err, busy;

   morse_decoder #(.MORSE_CYCLES(MC)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .morse_i (morse),
      .ascii_o (ascii),
      .valid_o (valid),
      .err_o   (err),
      .busy_o  (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Emission monitor
   logic [8:0] got_q[$];
   int         got_t[$];
   int         run_len = 0;
   int         max_run = 0;
   int         last_t  = -100000;
   int         min_sep = 100000;

   always @(negedge clk) begin
      if (valid) begin
         got_q.push_back({err, ascii});
         got_t.push_back(cyc);
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (run_len == 1) begin
            if (cyc - last_t < min_sep) min_sep = cyc - last_t;
            last_t = cyc;
         end
      end else begin
         run_len = 0;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: standard morse table and reverse lookup by search.
   function automatic string morse_of(input byte c);
      case (c)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";
         "D": return "-..";   "E": return ".";     "F": return "..-.";
         "G": return "--.";   "H": return "....";  "I": return "..";
         "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";
         "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
         "S": return "...";   "T": return "-";     "U": return "..-";
         "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---";
         "3": return "...--"; "4": return "....-"; "5": return ".....";
         "6": return "-...."; "7": return "--..."; "8": return "---..";
         "9": return "----.";
         default: return "";
      endcase
   endfunction

   function automatic logic [8:0] ref_decode(input string pat);
      string alpha;
      alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
      if (pat.len() > 6) return {1'b1, 8'h3F};
      for (int i = 0; i < alpha.len(); i++)
         if (morse_of(alpha[i]) == pat) return {1'b0, alpha[i]};
      return {1'b1, 8'h3F};
   endfunction

   // Drive helpers; always entered and left at a negedge.
   task automatic level(input logic v, input int n);
      morse = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_pattern(input string pat, input int dot, input int dash, input int gap);
      for (int i = 0; i < pat.len(); i++) begin
         level(1'b1, (pat[i] == ".") ? dot : dash);
         if (i != pat.len() - 1) level(1'b0, gap);
      end
   endtask

   task automatic expect_seq(input string name, input logic [8:0] exp[$]);
      int n;
      check({name, " count"}, got_q.size(), exp.size());
      n = (got_q.size() < exp.size()) ? got_q.size() : exp.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s[%0d] ascii", name, i), got_q[i][7:0], exp[i][7:0]);
         check($sformatf("%s[%0d] err", name, i), got_q[i][8], exp[i][8]);
      end
      got_q.delete();
      got_t.delete();
   endtask

   typedef struct {
      string      pat;
      logic [7:0] a;
      logic       e;
   } vec_t;

   vec_t       vecs[13];
   logic [8:0] eq[$];

   initial begin
      int p_fall, lat;

      vecs[0]  = '{".-",      8'h41, 1'b0};
      vecs[1]  = '{".",       8'h45, 1'b0};
      vecs[2]  = '{"-",       8'h54, 1'b0};
      vecs[3]  = '{".....",   8'h35, 1'b0};
      vecs[4]  = '{"-----",   8'h30, 1'b0};
      vecs[5]  = '{"----.",   8'h39, 1'b0};
      vecs[6]  = '{"--..",    8'h5A, 1'b0};
      vecs[7]  = '{"-.--",    8'h59, 1'b0};
      vecs[8]  = '{".......", 8'h3F, 1'b1};
      vecs[9]  = '{"------",  8'h3F, 1'b1};
      vecs[10] = '{"......",  8'h3F, 1'b1};
      vecs[11] = '{"..--",    8'h3F, 1'b1};
      vecs[12] = '{".-.-.-",  8'h3F, 1'b1};

      // Reset state
      reset = 1'b1;
      morse = 1'b0;
      repeat (3) @(negedge clk);
      check("reset ascii", ascii, 8'h00);
      check("reset valid", valid, 0);
      check("reset err",   err,   0);
      check("reset busy",  busy,  0);
      reset = 1'b0;
      level(1'b0, 20);
      check("idle busy", busy, 0);

      // 'A' with latency of letter and space
      level(1'b1, 11);
      level(1'b0, 11);
      level(1'b1, 31);
      p_fall = cyc;
      check("A busy", busy, 1);
      level(1'b0, 90);
      lat = (got_t.size() > 0) ? got_t[0] - p_fall : -1;
      check("A letter latency in 21..24", int'(lat >= 21 && lat <= 24), 1);
      check("A space after letter", (got_t.size() > 1) ? got_t[1] - got_t[0] : -1, 3 * MC);
      eq = '{9'h041, 9'h020};
      expect_seq("A", eq);
      check("A busy after word gap", busy, 0);

      // "E T": one space only, then nothing more on long idle
      level(1'b1, 11);
      level(1'b0, 80);
      level(1'b1, 31);
      level(1'b0, 300);
      eq = '{9'h045, 9'h020, 9'h054, 9'h020};
      expect_seq("E_T", eq);

      // Reset in the middle of the second mark of 'A'
      level(1'b1, 11);
      level(1'b0, 11);
      level(1'b1, 10);
      reset = 1'b1;
      level(1'b1, 2);
      reset = 1'b0;
      level(1'b0, 100);
      eq = {};
      expect_seq("reset_mid", eq);
      check("reset_mid ascii", ascii, 8'h00);
      check("reset_mid err",   err,   0);
      check("reset_mid busy",  busy,  0);

      // Table-driven single letters, each followed by a word gap
      for (int v = 0; v < 13; v++) begin
         send_pattern(vecs[v].pat, 11, 31, 11);
         level(1'b0, 70);
         eq = '{{vecs[v].e, vecs[v].a}, 9'h020};
         expect_seq($sformatf("vec%0d", v), eq);
      end

      // "SOS 5" with transmitter-style timing
      send_pattern("...", 11, 31, 11); level(1'b0, 31);
      send_pattern("---", 11, 31, 11); level(1'b0, 31);
      send_pattern("...", 11, 31, 11); level(1'b0, 71);
      send_pattern(".....", 11, 31, 11); level(1'b0, 100);
      eq = '{9'h053, 9'h04F, 9'h053, 9'h020, 9'h035, 9'h020};
      expect_seq("SOS_5", eq);

      // Random letters and codes with jittered durations
      eq = {};
      for (int t = 0; t < 60; t++) begin
         string pat, alpha, sym;
         bit    word;
         alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
         if ($urandom_range(0, 4) != 0) begin
            pat = morse_of(alpha[$urandom_range(0, 35)]);
         end else begin
            pat = "";
            for (int k = 0, n = $urandom_range(1, 7); k < n; k++) begin
               sym = ($urandom_range(0, 1) != 0) ? "." : "-";
               pat = {pat, sym};
            end
         end
         eq.push_back(ref_decode(pat));
         for (int i = 0; i < pat.len(); i++) begin
            level(1'b1, (pat[i] == ".") ? $urandom_range(6, 14) : $urandom_range(25, 40));
            if (i != pat.len() - 1) level(1'b0, $urandom_range(6, 15));
         end
         word = (t == 59) || ($urandom_range(0, 3) == 0);
         if (word) begin
            eq.push_back(9'h020);
            level(1'b0, $urandom_range(55, 90));
         end else begin
            level(1'b0, $urandom_range(25, 40));
         end
      end
      level(1'b0, 60);
      expect_seq("random", eq);

      check("valid pulse width", max_run, 1);
      check("min valid spacing >= 3 units", int'(min_sep >= 3 * MC), 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
